// File: rtl/cpu_dmem_sequencer.sv
// cpu_dmem_sequencer
// Turns one CPU data-memory request (byte / short / long, load or store) into
// one or two beats on a 16-bit big-endian Wishbone master port. It returns a
// single-cycle completion pulse carrying load data or an error flag.
//
// State table
//   IDLE  | waiting for a request; req_ready_o = !flush_i
//   BEAT0 | first (or only) bus beat: address addr, data [31:16] for longs
//   BEAT1 | second beat of a long access: address addr+2, data [15:0]
//   RESP  | rsp_valid_o high for this one cycle, then back to IDLE
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   flush_i                      blocks acceptance only; never aborts a transfer
//   req_*                        execute-stage request (valid/ready handshake)
//   rsp_valid_o/rdata_o/err_o    completion pulse, zero-extended load data
//   busy_o                       high whenever the machine is not IDLE
//   dmem_*                       16-bit Wishbone master (registered outputs)
module cpu_dmem_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [31:0] dmem_address_o,
    output logic [15:0] dmem_data_o,
    input  logic [15:0] dmem_data_i,
    output logic [1:0]  dmem_sel_o,
    output logic        dmem_we_o,
    output logic        dmem_stb_o,
    output logic        dmem_cyc_o,
    input  logic        dmem_ack_i
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_SHORT = 2'b01;
    localparam logic [1:0] SZ_LONG  = 2'b10;
    // Abort on the edge that ends the TIMEOUT_CYCLES-th unacknowledged cycle.
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        addr_lsb_q, addr_lsb_d;
    logic [15:0] wdata_lo_q, wdata_lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        dwe_q, dwe_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        bad_req;
    logic [31:0] beat_rdata;

    assign req_ready_o    = (state_q == IDLE) && !flush_i;
    assign accept         = req_valid_i && req_ready_o;
    assign bad_req        = (req_size_i == 2'b11) ||
                            ((req_size_i != SZ_BYTE) && req_addr_i[0]);

    assign busy_o         = (state_q != IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign dmem_cyc_o     = cyc_q;
    assign dmem_stb_o     = stb_q;
    assign dmem_we_o      = dwe_q;
    assign dmem_sel_o     = sel_q;
    assign dmem_address_o = adr_q;
    assign dmem_data_o    = dat_q;

    // Load data as it will stand after capturing the current beat.
    always_comb begin
        beat_rdata = rdata_q;
        case (size_q)
            SZ_BYTE:  beat_rdata = {24'b0, addr_lsb_q ? dmem_data_i[7:0] : dmem_data_i[15:8]};
            SZ_SHORT: beat_rdata = {16'b0, dmem_data_i};
            default: begin
                if (state_q == BEAT0) beat_rdata = {dmem_data_i, 16'b0};
                else                  beat_rdata = {rdata_q[31:16], dmem_data_i};
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_lsb_d  = addr_lsb_q;
        wdata_lo_d  = wdata_lo_q;
        rdata_d     = rdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        dwe_d       = dwe_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d       = req_we_i;
                    size_d     = req_size_i;
                    addr_lsb_d = req_addr_i[0];
                    wdata_lo_d = req_wdata_i[15:0];
                    rdata_d    = 32'b0;
                    tmo_cnt_d  = 8'd0;
                    if (bad_req) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = BEAT0;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        dwe_d   = req_we_i;
                        adr_d   = {req_addr_i[31:1], 1'b0};
                        case (req_size_i)
                            SZ_BYTE: begin
                                sel_d = req_addr_i[0] ? 2'b01 : 2'b10;
                                dat_d = {req_wdata_i[7:0], req_wdata_i[7:0]};
                            end
                            SZ_SHORT: begin
                                sel_d = 2'b11;
                                dat_d = req_wdata_i[15:0];
                            end
                            default: begin
                                sel_d = 2'b11;
                                dat_d = req_wdata_i[31:16];
                            end
                        endcase
                    end
                end
            end

            BEAT0, BEAT1: begin
                if (dmem_ack_i) begin
                    rdata_d   = beat_rdata;
                    tmo_cnt_d = 8'd0;
                    if ((state_q == BEAT0) && (size_q == SZ_LONG)) begin
                        state_d = BEAT1;
                        adr_d   = adr_q + 32'd2;
                        dat_d   = wdata_lo_q;
                    end else begin
                        state_d     = RESP;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        dwe_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = we_q ? 32'b0 : beat_rdata;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_cnt_q == TO_LAST) begin
                        state_d     = RESP;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        dwe_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_lsb_q  <= 1'b0;
            wdata_lo_q  <= 16'b0;
            rdata_q     <= 32'b0;
            tmo_cnt_q   <= 8'd0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            dwe_q       <= 1'b0;
            sel_q       <= 2'b00;
            adr_q       <= 32'b0;
            dat_q       <= 16'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_lsb_q  <= addr_lsb_d;
            wdata_lo_q  <= wdata_lo_d;
            rdata_q     <= rdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            dwe_q       <= dwe_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_cpu_dmem_sequencer.sv
module tb_cpu_dmem_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic [31:0] dmem_address_o;
    logic [15:0] dmem_data_o;
    logic [15:0] dmem_data_i;
    logic [1:0]  dmem_sel_o;
    logic        dmem_we_o;
    logic        dmem_stb_o;
    logic        dmem_cyc_o;
    logic        dmem_ack_i;

    cpu_dmem_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .dmem_address_o(dmem_address_o), .dmem_data_o(dmem_data_o),
        .dmem_data_i(dmem_data_i), .dmem_sel_o(dmem_sel_o),
        .dmem_we_o(dmem_we_o), .dmem_stb_o(dmem_stb_o),
        .dmem_cyc_o(dmem_cyc_o), .dmem_ack_i(dmem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   rsp_seen = 0;
    int   rsp_pushed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
        rsp_pushed++;
    endtask

    // Scoreboard: every completion pulse is popped and compared.
    always @(negedge clk_i) begin
        if (rsp_valid_o === 1'b1) begin
            rsp_t e;
            rsp_seen++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $error("FAIL unexpected_rsp observed rdata=0x%08h err=%0b expected no response",
                       rsp_rdata_o, rsp_err_o);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
            end
        end
    end

    // Drives one request for one cycle; returns at the negedge after acceptance.
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = size;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        check("req_ready", {31'b0, req_ready_o}, 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_wdata_i = 32'b0;
    endtask

    // Waits for a strobe, checks the beat, acks it for one cycle.
    task automatic beat(input string tag, input logic [31:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input logic we, input logic [15:0] rd);
        int n;
        n = 0;
        while (dmem_stb_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (dmem_stb_o !== 1'b1) begin
            total_cnt++;
            $error("FAIL %s_stb_wait observed no strobe within 20 cycles expected strobe", tag);
        end else begin
            check({tag, "_adr"}, dmem_address_o, adr);
            check({tag, "_sel"}, {30'b0, dmem_sel_o}, {30'b0, sel});
            check({tag, "_we"}, {31'b0, dmem_we_o}, {31'b0, we});
            check({tag, "_cyc"}, {31'b0, dmem_cyc_o}, 32'd1);
            if (we) check({tag, "_dat"}, {16'b0, dmem_data_o}, {16'b0, dat});
            dmem_ack_i  = 1'b1;
            dmem_data_i = rd;
            @(negedge clk_i);
            dmem_ack_i  = 1'b0;
            dmem_data_i = 16'h0;
        end
    endtask

    initial begin
        int n;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_size_i  = 2'b00;
        req_addr_i  = 32'b0;
        req_wdata_i = 32'b0;
        dmem_data_i = 16'h0;
        dmem_ack_i  = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst_cyc", {31'b0, dmem_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, dmem_stb_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_adr", dmem_address_o, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Long store, ack one cycle after each strobe
        expect_rsp(32'h0, 1'b0);
        do_req(1'b1, 2'b10, 32'h100, 32'h12345678);
        check("ls_stb_n1", {31'b0, dmem_stb_o}, 32'd1);
        check("ls_busy", {31'b0, busy_o}, 32'd1);
        beat("ls_b0", 32'h100, 16'h1234, 2'b11, 1'b1, 16'h0);
        check("ls_cyc_cont", {31'b0, dmem_cyc_o}, 32'd1);
        beat("ls_b1", 32'h102, 16'h5678, 2'b11, 1'b1, 16'h0);
        check("ls_rsp_lat", {31'b0, rsp_valid_o}, 32'd1);
        check("ls_cyc_drop", {31'b0, dmem_cyc_o}, 32'd0);
        @(negedge clk_i);
        check("ls_rsp_pulse", {31'b0, rsp_valid_o}, 32'd0);
        check("ls_ready", {31'b0, req_ready_o}, 32'd1);

        // Long load
        expect_rsp(32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'b10, 32'h200, 32'h0);
        beat("ll_b0", 32'h200, 16'h0, 2'b11, 1'b0, 16'hDEAD);
        beat("ll_b1", 32'h202, 16'h0, 2'b11, 1'b0, 16'hBEEF);
        @(negedge clk_i);

        // Byte loads, odd then even lane
        expect_rsp(32'h00000055, 1'b0);
        do_req(1'b0, 2'b00, 32'h301, 32'h0);
        beat("bl_odd", 32'h300, 16'h0, 2'b01, 1'b0, 16'hAA55);
        @(negedge clk_i);
        expect_rsp(32'h000000AA, 1'b0);
        do_req(1'b0, 2'b00, 32'h300, 32'h0);
        beat("bl_even", 32'h300, 16'h0, 2'b10, 1'b0, 16'hAA55);
        @(negedge clk_i);

        // Byte store replicates the byte on both lanes
        expect_rsp(32'h0, 1'b0);
        do_req(1'b1, 2'b00, 32'h303, 32'hFFFF_FFA5);
        beat("bs", 32'h302, 16'hA5A5, 2'b01, 1'b1, 16'h0);
        @(negedge clk_i);

        // Short load with flush raised mid-flight
        expect_rsp(32'h00001357, 1'b0);
        do_req(1'b0, 2'b01, 32'h402, 32'h0);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("fl_stb_held", {31'b0, dmem_stb_o}, 32'd1);
        beat("sl_flush", 32'h402, 16'h0, 2'b11, 1'b0, 16'h1357);
        @(negedge clk_i);
        check("fl_ready_blocked", {31'b0, req_ready_o}, 32'd0);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("fl_not_accepted", {31'b0, busy_o}, 32'd0);
        flush_i = 1'b0;
        @(negedge clk_i);

        // Misaligned short store: no bus cycle, error response
        expect_rsp(32'h0, 1'b1);
        do_req(1'b1, 2'b01, 32'h401, 32'h1234);
        check("mis_no_stb", {31'b0, dmem_stb_o}, 32'd0);
        check("mis_rsp", {31'b0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);

        // Reserved size
        expect_rsp(32'h0, 1'b1);
        do_req(1'b0, 2'b11, 32'h700, 32'h0);
        check("rsv_no_cyc", {31'b0, dmem_cyc_o}, 32'd0);
        @(negedge clk_i);

        // Timeout: no ack, strobe held TIMEOUT_CYCLES cycles
        expect_rsp(32'h0, 1'b1);
        do_req(1'b0, 2'b10, 32'h500, 32'h0);
        n = 0;
        while (dmem_stb_o === 1'b1 && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        check("to_stb_cycles", n, 32'd4);
        check("to_cyc_drop", {31'b0, dmem_cyc_o}, 32'd0);
        check("to_rsp", {31'b0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);

        // Ack while idle is ignored
        dmem_ack_i = 1'b1;
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        check("idle_ack_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);

        // Reset during BEAT1 of a long store
        do_req(1'b1, 2'b10, 32'h600, 32'hCAFEF00D);
        beat("rs_b0", 32'h600, 16'hCAFE, 2'b11, 1'b1, 16'h0);
        check("rs_b1_stb", {31'b0, dmem_stb_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rs_async_cyc", {31'b0, dmem_cyc_o}, 32'd0);
        check("rs_async_stb", {31'b0, dmem_stb_o}, 32'd0);
        check("rs_async_busy", {31'b0, busy_o}, 32'd0);
        check("rs_async_sel", {30'b0, dmem_sel_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rs_ready", {31'b0, req_ready_o}, 32'd1);
        repeat (3) @(negedge clk_i);

        check("sb_empty", exp_q.size(), 32'd0);
        check("rsp_count", rsp_seen, rsp_pushed);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed sim still running expected finish");
        $fatal(1);
    end

endmodule
